// File: rtl/ndp_tile_sequencer.sv
// Sequencer for one matrix-multiply pass of the NDP systolic array bank:
// clear accumulators, stream K operand pairs, drain the skew, flag completion.
module ndp_tile_sequencer #(
    parameter int unsigned ARR_WIDTH    = 4,
    parameter int unsigned ARR_HEIGHT   = 4,
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned DRAIN_CYCLES = ARR_WIDTH + ARR_HEIGHT - 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [15:0]           k_len,
    input  logic [ADDR_WIDTH-1:0] base_addr_a,
    input  logic [ADDR_WIDTH-1:0] base_addr_b,
    input  logic                  stall,
    output logic                  sp_rd_en,
    output logic [ADDR_WIDTH-1:0] sp_rd_addr_a,
    output logic [ADDR_WIDTH-1:0] sp_rd_addr_b,
    output logic                  array_clear,
    output logic                  array_en,
    output logic                  feed_zero,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [31:0]           cycle_count
);

    localparam int unsigned D_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [D_W-1:0] D_LAST = D_W'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DRAIN, S_DONE
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  start_q;
    logic                  rd_en_q;
    logic [15:0]           k_q;
    logic [15:0]           i_q;
    logic [D_W-1:0]        d_q;
    logic [ADDR_WIDTH-1:0] base_a_q;
    logic [ADDR_WIDTH-1:0] base_b_q;
    logic                  start_pulse_c;
    logic                  accept_c;

    assign start_pulse_c = start & ~start_q;
    assign accept_c      = (state_q == S_IDLE) & start_pulse_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_pulse_c) begin
                    state_d = (k_len == 16'd0) ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: state_d = S_FEED;
            S_FEED: begin
                if (!stall && (i_q == k_q - 16'd1)) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: state_d = S_DRAIN;
            S_DRAIN: begin
                if (!stall && (d_q == D_LAST)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; array_en also covers the cycle after each issued read
    always_comb begin
        sp_rd_en     = 1'b0;
        sp_rd_addr_a = '0;
        sp_rd_addr_b = '0;
        array_clear  = 1'b0;
        array_en     = rd_en_q;
        feed_zero    = 1'b0;
        busy         = 1'b0;
        case (state_q)
            S_CLEAR: begin
                array_clear = 1'b1;
                busy        = 1'b1;
            end
            S_FEED: begin
                busy = 1'b1;
                if (!stall) begin
                    sp_rd_en     = 1'b1;
                    sp_rd_addr_a = base_a_q + ADDR_WIDTH'(i_q);
                    sp_rd_addr_b = base_b_q + ADDR_WIDTH'(i_q);
                end
            end
            S_FLUSH: busy = 1'b1;
            S_DRAIN: begin
                busy      = 1'b1;
                feed_zero = 1'b1;
                array_en  = rd_en_q | ~stall;
            end
            default: ;
        endcase
    end

    // Pass context, step counters and sticky status
    always_ff @(posedge clk) begin
        if (reset) begin
            start_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            k_q         <= '0;
            i_q         <= '0;
            d_q         <= '0;
            base_a_q    <= '0;
            base_b_q    <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            cycle_count <= '0;
        end else begin
            start_q <= start;
            rd_en_q <= sp_rd_en;
            if (accept_c) begin
                k_q         <= k_len;
                base_a_q    <= base_addr_a;
                base_b_q    <= base_addr_b;
                i_q         <= '0;
                d_q         <= '0;
                done        <= 1'b0;
                err         <= (k_len == 16'd0);
                cycle_count <= '0;
            end else begin
                if (busy && (cycle_count != 32'hFFFF_FFFF)) begin
                    cycle_count <= cycle_count + 32'd1;
                end
                if (sp_rd_en) begin
                    i_q <= i_q + 16'd1;
                end
                if ((state_q == S_DRAIN) && !stall) begin
                    d_q <= d_q + D_W'(1);
                end
                // done is visible in the DONE cycle itself when arriving from DRAIN
                if ((state_q == S_DONE) || ((state_q == S_DRAIN) && (state_d == S_DONE))) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule
